// File: rtl/sim_uart_bridge.sv
// Simulation console bridge: buffers core output chars for the host (TX FIFO),
// buffers host input chars for the core (RX FIFO), and keeps a free-running
// cycle counter that drives a registered log-enable window.
module sim_uart_bridge #(
  parameter int              DEPTH  = 16,
  parameter int              CH_W   = 8,
  parameter int              CYC_W  = 64,
  parameter logic [CH_W-1:0] EOF_CH = '1,
  localparam int             ADDR_W = $clog2(DEPTH),
  localparam int             PTR_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CYC_W-1:0]  log_begin,
  input  logic [CYC_W-1:0]  log_end,
  input  logic              core_out_valid,
  input  logic [CH_W-1:0]   core_out_ch,
  input  logic              core_in_valid,
  output logic [CH_W-1:0]   core_in_ch,
  output logic              host_tx_valid,
  output logic [CH_W-1:0]   host_tx_ch,
  input  logic              host_tx_ready,
  input  logic              host_rx_valid,
  input  logic [CH_W-1:0]   host_rx_ch,
  output logic              host_rx_ready,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic              log_en,
  output logic [PTR_W-1:0]  tx_level,
  output logic [15:0]       tx_drop_cnt
);

  // Storage arrays; contents are never reset, only the pointers are.
  logic [CH_W-1:0]  tx_mem [DEPTH];
  logic [CH_W-1:0]  rx_mem [DEPTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PTR_W-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [PTR_W-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;

  logic tx_empty, tx_full, tx_push, tx_pop, tx_drop;
  logic rx_empty, rx_full, rx_push, rx_pop;

  // FIFO status and handshake decode.
  always_comb begin
    tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    tx_full  = (tx_wr_ptr_reg[ADDR_W] != tx_rd_ptr_reg[ADDR_W]) &&
               (tx_wr_ptr_reg[ADDR_W-1:0] == tx_rd_ptr_reg[ADDR_W-1:0]);
    rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    rx_full  = (rx_wr_ptr_reg[ADDR_W] != rx_rd_ptr_reg[ADDR_W]) &&
               (rx_wr_ptr_reg[ADDR_W-1:0] == rx_rd_ptr_reg[ADDR_W-1:0]);

    // A full TX FIFO still accepts a char when the host pops the head in the
    // same cycle, since the core cannot be stalled.
    tx_pop   = !tx_empty && host_tx_ready;
    tx_push  = core_out_valid && (!tx_full || tx_pop);
    tx_drop  = core_out_valid && tx_full && !tx_pop;

    rx_push  = host_rx_valid && !rx_full;
    rx_pop   = core_in_valid && !rx_empty;
  end

  // Output views of FIFO heads and levels.
  always_comb begin
    host_tx_valid = !tx_empty;
    host_tx_ch    = tx_mem[tx_rd_ptr_reg[ADDR_W-1:0]];
    host_rx_ready = !rx_full;
    core_in_ch    = rx_empty ? EOF_CH : rx_mem[rx_rd_ptr_reg[ADDR_W-1:0]];
    tx_level      = tx_wr_ptr_reg - tx_rd_ptr_reg;
  end

  // Storage writes; a write during reset is harmless because pointers clear.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[ADDR_W-1:0]] <= core_out_ch;
    if (rx_push) rx_mem[rx_wr_ptr_reg[ADDR_W-1:0]] <= host_rx_ch;
  end

  // TX pointers and saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_drop_cnt   <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_W'(1);
      if (tx_drop && (tx_drop_cnt != 16'hFFFF)) tx_drop_cnt <= tx_drop_cnt + 16'd1;
    end
  end

  // RX pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_W'(1);
    end
  end

  // Free-running cycle counter and log window flag, which lags the counter
  // by one cycle because it is computed from the pre-edge count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
      log_en    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + CYC_W'(1);
      log_en    <= (cycle_cnt >= log_begin) && (cycle_cnt < log_end);
    end
  end

endmodule

// File: doc/sim_uart_bridge.md
# sim_uart_bridge

Parametrised simulation console bridge between the core's `io_uart_*` ports and the host-side testbench driver. It buffers core output characters in a TX FIFO drained by a ready/valid host port. It buffers host-supplied input characters in an RX FIFO that answers the core's input-request strobes. It also keeps a free-running cycle counter that gates a log-enable window from `log_begin`/`log_end`. It replaces the bare pass-through hookup in the simulation top.

## Interface
- `DEPTH`, 16, entries per FIFO; power of two, at least 2.
- `CH_W`, 8, character width.
- `CYC_W`, 64, cycle counter and log-window width.
- `EOF_CH`, all-ones, value returned to the core when the RX FIFO is empty.

Ports:
- `clock`  in  1  single clock; all state on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `log_begin`  in  CYC_W  first logged cycle, inclusive.
- `log_end`  in  CYC_W  log window end, exclusive.
- `core_out_valid`  in  1  one-cycle strobe; core emits a char.
- `core_out_ch`  in  CH_W  emitted char.
- `core_in_valid`  in  1  one-cycle strobe; core requests a char.
- `core_in_ch`  out  CH_W  RX FIFO head, or EOF_CH when empty; combinational.
- `host_tx_valid`  out  1  TX FIFO non-empty.
- `host_tx_ch`  out  CH_W  TX FIFO head.
- `host_tx_ready`  in  1  host accepts the head char.
- `host_rx_valid`  in  1  host offers an input char.
- `host_rx_ch`  in  CH_W  offered char.
- `host_rx_ready`  out  1  RX FIFO not full.
- `cycle_cnt`  out  CYC_W  cycles since reset release.
- `log_en`  out  1  registered log-window flag.
- `tx_level`  out  clog2(DEPTH)+1  TX FIFO occupancy.
- `tx_drop_cnt`  out  16  TX chars lost to overflow; saturating.

## Operation
- **TX FIFO**
  - push = `core_out_valid && (!tx_full || tx_pop)`.
  - pop = `host_tx_valid && host_tx_ready`.
  - Full with simultaneous pop: the push is accepted and occupancy is unchanged.
  - `core_out_valid` while full without a pop: char dropped; `tx_drop_cnt` += 1, saturating at 0xFFFF.
  - The core has no backpressure.
- **RX FIFO**
  - push = `host_rx_valid && host_rx_ready`.
  - pop = `core_in_valid && !rx_empty`.
  - `host_rx_ready = !rx_full`, so there is no full-with-pop pass-through on the RX side.
  - `core_in_valid` while empty: `core_in_ch = EOF_CH`, no pop, no state change.
- **Pointers**
  - Read/write pointers are clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Wrap is modulo 2·DEPTH.
  - Storage is a register array, not reset.
- **Cycle counter**
  - +1 every non-reset cycle; wraps to 0 after all-ones.
- **Log window**
  - `log_en` next = `(cycle_cnt >= log_begin) && (cycle_cnt < log_end)`, unsigned compare.
  - If `log_end <= log_begin`, `log_en` stays 0.
- **Reset mid-operation**
  - Both FIFOs empty immediately.
  - Buffered chars are discarded and not counted as drops.

## Timing
- **Reset values**
  - `host_tx_valid`=0, `host_rx_ready`=1 (from the cycle after reset), `core_in_ch`=EOF_CH.
  - `cycle_cnt`=0, `log_en`=0, `tx_level`=0, `tx_drop_cnt`=0.
- **TX latency**
  - A char pushed at edge N appears on `host_tx_valid`/`host_tx_ch` after edge N; host can pop at edge N+1.
  - No bypass path: an empty FIFO never presents an incoming char in the same cycle.
- **RX latency**
  - A host char accepted at edge N is visible on `core_in_ch` after edge N.
  - A core pop at edge N+1 exposes the next entry, or EOF_CH.
- **Other outputs**
  - `tx_level` reflects occupancy after the last edge.
  - `log_en` lags `cycle_cnt` by one cycle: `log_en` is high during cycles where the registered `cycle_cnt` is in [log_begin+1, log_end].
- **Handshake rules**
  - The host must hold `host_rx_ch` stable while `host_rx_valid && !host_rx_ready`.
  - `host_tx_valid` never drops without a pop; only reset clears it.

## Test plan
- **TX basic.** Reset, then push 'H','i' (0x48, 0x69) on consecutive cycles with `host_tx_ready`=1. Required: `host_tx_ch` = 0x48 then 0x69 on consecutive cycles; `tx_level` returns to 0; `tx_drop_cnt`=0.
- **TX overflow.** `host_tx_ready`=0, push 20 chars 0x00..0x13 with DEPTH=16. Required: `tx_level`=16, `tx_drop_cnt`=4. Draining yields 0x00..0x0F in order. Full with simultaneous push+pop keeps `tx_level`=16 with no drop.
- **RX/EOF.**
  - `core_in_valid` on empty: `core_in_ch`=0xFF, no state change.
  - Host sends 0x41, 0x42: the next two strobes return 0x41 then 0x42; the third returns 0xFF.
  - With 16 entries queued, `host_rx_ready`=0.
- **Log window.** `log_begin`=10, `log_end`=13. Required: `log_en`=1 exactly while `cycle_cnt` reads 11..13, i.e. three cycles. `log_begin`=13, `log_end`=10: `log_en` never asserts.
- **Reset mid-operation.** TX holds 5 chars, RX holds 3. Assert `reset` for 1 cycle. Required: `host_tx_valid`=0, `core_in_ch`=0xFF, `cycle_cnt`=0, `tx_drop_cnt`=0. A subsequent push 0x55 appears one cycle later.
- **Counter wrap.** With CYC_W=4, run 20 cycles after reset. Required: `cycle_cnt` reads 15 at cycle 15, then 0, and ends at 4.
